// File: rtl/mod503_unscale_500_pkg.sv
// Shared constants, FSM state encoding and the modular reduction helper
// for the mod-503 unscaling decoder.
package mod503_pkg;

    localparam int W   = 9;    // residue width
    localparam int MOD = 503;  // modulus, odd and < 2^W
    localparam int INV = 335;  // 500^-1 mod 503, < 2^W

    // Width of the MSB-first bit counter over the W constant bits.
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One conditional subtraction. Any value below 2*MOD becomes canonical.
    function automatic logic [W:0] reduce_once(input logic [W:0] v);
        return (v >= (W+1)'(MOD)) ? v - (W+1)'(MOD) : v;
    endfunction

endpackage

// File: rtl/mod503_unscale_500_if.sv
// Valid/ready input and output channels of the unscaling decoder.
interface mod503_unscale_500_if;
    import mod503_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    // Decoder side: consumes residues, produces unscaled results.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Environment side: offers residues and drains results.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/mod503_unscale_500_dbl_add.sv
// One double-and-add step: sum = (2*acc + bit*r) mod MOD.
// Both operands are canonical, so each stage needs a single reduction
// and every intermediate fits in W+1 bits.
module mod503_dbl_add
    import mod503_pkg::*;
(
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] r_i,
    input  logic         bit_i,
    output logic [W-1:0] sum_o
);

    logic [W:0] dbl_red;
    logic [W:0] add_raw;

    // Double, reduce, conditionally add r, reduce again.
    always_comb begin
        dbl_red = reduce_once({acc_i, 1'b0});
        add_raw = dbl_red + (bit_i ? {1'b0, r_i} : '0);
        sum_o   = W'(reduce_once(add_raw));
    end

endmodule

// File: rtl/mod503_unscale_500.sv
// Sequential decoder: x = y * INV mod MOD, computed bit-serially MSB-first
// over the W bits of INV, with valid/ready handshakes on both sides.
module mod503_unscale_500
    import mod503_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mod503_unscale_500_if.slave  bus,
    output logic                 busy
);

    localparam logic [W-1:0] INV_BITS = W'(INV);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       r_q;
    logic [W-1:0]       acc_q;
    logic [W-1:0]       out_data_q;
    logic [W-1:0]       step_sum;
    logic               inv_bit;

    assign inv_bit = INV_BITS[cnt_q];

    mod503_dbl_add u_dbl_add (
        .acc_i (acc_q),
        .r_i   (r_q),
        .bit_i (inv_bit),
        .sum_o (step_sum)
    );

    // State register; reset wins over everything, including mid-RUN.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, W steps in RUN, hold DONE until drained.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)      state_d = RUN;
            RUN:     if (cnt_q == '0)       state_d = DONE;
            DONE:    if (bus.out_ready)     state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only; no input-to-output combinational path.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        busy          = (state_q != IDLE);
    end

    assign bus.out_data = out_data_q;

    // Datapath: latch canonical r on accept, iterate acc, publish final result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            r_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_q   <= W'(reduce_once({1'b0, bus.in_data}));
                        acc_q <= '0;
                        cnt_q <= CNT_W'(W - 1);
                    end
                end
                RUN: begin
                    acc_q <= step_sum;
                    if (cnt_q == '0) begin
                        out_data_q <= step_sum;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    // DONE: result held in out_data_q until the next completion.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod503_unscale_500.sv
// Directed bench for the mod-503 unscaling decoder.
module tb_mod503_unscale_500;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    mod503_unscale_500_if bus ();

    mod503_unscale_500 dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait (bounded) for out_valid, sampled on falling edges.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Offer y at a falling edge in IDLE, then wait for the result.
    // lat counts rising edges from the accept edge (inclusive) through the
    // edge that raises out_valid.
    task automatic collect(input logic [8:0] y, output logic [8:0] got,
                           output int lat, output bit ok);
        ok = 1'b0;
        got = 'x;
        bus.in_valid = 1'b1;
        bus.in_data  = y;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = ~y;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = bus.out_data;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compared += 4;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        if (bus.out_data !== 9'd0) begin mismatched++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_first();
        logic [8:0] got; int lat; bit ok;
        collect(9'd500, got, lat, ok);
        compared += 3;
        if (!ok) begin mismatched++; $display("FAIL first_timeout got no out_valid want out_valid"); end
        if (lat !== 10) begin mismatched++; $display("FAIL first_latency got %0d want 10", lat); end
        if (got !== 9'd1) begin mismatched++; $display("FAIL first_data got %0d want 1", got); end
        drain();
    endtask

    task automatic test_vectors();
        logic [8:0] ys [4];
        logic [8:0] ex [4];
        logic [8:0] got; int lat; bit ok;
        ys = '{9'd0, 9'd1, 9'd3, 9'd502};
        ex = '{9'd0, 9'd335, 9'd502, 9'd168};
        for (int k = 0; k < 4; k++) begin
            collect(ys[k], got, lat, ok);
            compared += 2;
            if (!ok) begin mismatched++; $display("FAIL vec_timeout y=%0d got no out_valid", ys[k]); end
            if (got !== ex[k]) begin mismatched++; $display("FAIL vec_data y=%0d got %0d want %0d", ys[k], got, ex[k]); end
            drain();
        end
    endtask

    task automatic test_noncanonical();
        logic [8:0] got; int lat; bit ok;
        collect(9'd510, got, lat, ok);
        compared += 2;
        if (!ok) begin mismatched++; $display("FAIL noncanon_timeout got no out_valid"); end
        if (got !== 9'd333) begin mismatched++; $display("FAIL noncanon_data got %0d want 333", got); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [8:0] got; int lat; bit ok;
        bit stuck;
        collect(9'd3, got, lat, ok);
        compared += 1;
        if (got !== 9'd502) begin mismatched++; $display("FAIL bp_data got %0d want 502", got); end
        bus.in_valid = 1'b1;
        bus.in_data  = 9'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            compared += 3;
            if (bus.out_data !== 9'd502) begin mismatched++; $display("FAIL bp_hold cyc %0d got %0d want 502", i, bus.out_data); end
            if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, bus.out_valid); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        compared += 2;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        stuck = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || bus.out_valid !== 1'b0) stuck = 1'b1;
        end
        compared += 2;
        if (stuck) begin mismatched++; $display("FAIL bp_no_accept got busy/out_valid activity want idle"); end
        if (bus.out_data !== 9'd502) begin mismatched++; $display("FAIL bp_keep_data got %0d want 502", bus.out_data); end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        bus.in_valid = 1'b1;
        bus.in_data  = 9'd1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared += 4;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL abort_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL abort_out_valid got %b want 0", bus.out_valid); end
        if (bus.out_data !== 9'd0) begin mismatched++; $display("FAIL abort_out_data got %0d want 0", bus.out_data); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy got %b want 0", busy); end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        compared += 1;
        if (seen) begin mismatched++; $display("FAIL abort_ghost got out_valid want none"); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] vals [3];
        logic [8:0] ex [3];
        int prev;
        bit ok;
        vals = '{9'd2, 9'd500, 9'd510};
        ex   = '{9'd167, 9'd1, 9'd333};
        prev = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                compared += 1;
                if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready k=%0d got %b want 1", k, bus.in_ready); end
            end
            bus.in_data  = vals[k];
            bus.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.in_data = 9'h1AA;
            wait_valid(ok);
            compared += 2;
            if (!ok) begin mismatched++; $display("FAIL b2b_timeout k=%0d got no out_valid", k); end
            if (bus.out_data !== ex[k]) begin mismatched++; $display("FAIL b2b_data k=%0d got %0d want %0d", k, bus.out_data, ex[k]); end
            if (k > 0) begin
                compared += 1;
                if (cyc - prev !== 11) begin mismatched++; $display("FAIL b2b_spacing k=%0d got %0d want 11", k, cyc - prev); end
            end
            prev = cyc;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_sweep();
        logic [8:0] got; int lat; bit ok;
        int exp_x;
        int bad_data, bad_lat, bad_hold;
        bad_data = 0; bad_lat = 0; bad_hold = 0;
        for (int y = 0; y < 512; y++) begin
            exp_x = ((y % 503) * 335) % 503;
            collect(9'(y), got, lat, ok);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            compared += 3;
            if (!ok || got !== 9'(exp_x)) begin
                mismatched++; bad_data++;
                if (bad_data <= 5) $display("FAIL sweep_data y=%0d got %0d want %0d", y, got, exp_x);
            end
            if (lat !== 10) begin
                mismatched++; bad_lat++;
                if (bad_lat <= 5) $display("FAIL sweep_latency y=%0d got %0d want 10", y, lat);
            end
            if (bus.out_valid !== 1'b1 || bus.out_data !== 9'(exp_x)) begin
                mismatched++; bad_hold++;
                if (bad_hold <= 5) $display("FAIL sweep_hold y=%0d got %0d want %0d", y, bus.out_data, exp_x);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_first();
        test_vectors();
        test_noncanonical();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mod503_unscale_500.md
# mod503_unscale_500

Sequential decoder that removes the ×500 scaling applied by the mod-503 chunk converters. It accepts a 9-bit residue y = 500·x mod 503 and returns x = y·335 mod 503, because 335 = 500⁻¹ mod 503. It sits at the output of the x_500 residue datapath and converts results back to plain residues. It uses a bit-serial, MSB-first double-and-add over the 9 constant bits, behind valid/ready handshakes on both sides.

## Interface
- MOD, 503: modulus; must be odd and less than 2^W.
- W, 9: residue width.
- INV, 335: constant multiplier, equal to 500⁻¹ mod MOD; must be less than 2^W.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input residue offered.
- in_ready  out  1  block can accept an input; high only in IDLE.
- in_data  in  W  residue y; values from MOD to 2^W−1 are accepted as non-canonical.
- out_valid  out  1  result held and valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  x = y·INV mod MOD, always in 0..MOD−1.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: 9 iterations.
  - DONE: out_valid=1.
- IDLE:
  - When in_valid=1, latch r = (in_data ≥ MOD) ? in_data−MOD : in_data.
  - Clear acc to 0, set cnt = W−1, go to RUN.
  - When in_valid=0, stay in IDLE.
- RUN, on each edge:
  - t = 2·acc; if t ≥ MOD then t −= MOD.
  - If INV[cnt]=1 then t += r; if t ≥ MOD then t −= MOD.
  - acc ← t.
  - If cnt=0, go to DONE; otherwise cnt−−.
- DONE:
  - out_data = acc, held stable.
  - When out_ready=1, go to IDLE.
  - out_data keeps its value after the transfer until the next DONE.
- Intermediate width is W+1 bits, enough for 2·(MOD−1). No other wider arithmetic is used.
- in_data is sampled only on the accepting edge. Changes to in_data during RUN or DONE have no effect.
- rst=1 has priority in any state, including mid-RUN:
  - state goes to IDLE; acc, r, cnt and out_data are cleared to 0.
  - the in-flight operation is dropped and produces no output.
- Reset values: in_ready=1 from the first cycle after the reset edge; out_valid=0, out_data=0, busy=0.

## Timing
- Accept happens on the edge where state=IDLE and in_valid=1.
- Exactly 9 RUN edges follow the accept edge.
- out_valid is first high in the cycle after the 9th RUN edge.
- Latency from the accept edge to the first out_valid cycle: 10 clocks.
- in_ready is combinationally state==IDLE and does not depend on in_valid.
- There is no overlap between operations. After the DONE→IDLE edge, the earliest next accept is on the following edge.
- Back-to-back throughput: one result per 11 clocks when out_ready is held high.
- Backpressure: DONE is held indefinitely with out_data stable.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Package mod503_pkg holds:
  - MOD, W and INV localparams;
  - the state enum {IDLE, RUN, DONE};
  - a function reduce_once(v) returning v ≥ MOD ? v−MOD : v.
- Sub-module mod503_dbl_add (combinational) takes acc, r and bit, and returns (2·acc + bit·r) mod MOD using two reduce_once stages.
- The top level holds the FSM, cnt, the r and acc registers, and the handshakes.

## Test plan
- Reset, then in_data=500 with one in_valid pulse → out_data=1, out_valid first high exactly 10 clocks after the accept edge.
- Inputs 0, 1, 3 and 502 → outputs 0, 335, 502 and 168 respectively.
- Non-canonical input in_data=510 → treated as 7, out_data=333.
- Backpressure: out_ready low for 20 cycles in DONE → out_data stays constant, in_ready stays 0, and an in_valid presented meanwhile is not accepted. Then one out_ready pulse → IDLE on the next edge.
- rst asserted on the 5th RUN cycle → next cycle state=IDLE, in_ready=1, out_valid=0, out_data=0, and no result ever appears for the aborted input.
- Exhaustive sweep of y over 0..511 with random out_ready stalls → every out_data equals (y mod 503)·335 mod 503, with ordering preserved and no lost or duplicated transfers.
